// File: rtl/dm_abstract_cmd_ctrl_pkg.sv
// Shared types and helpers for the debug-module abstract command sequencer.
// Provides command/cmderr encodings, the sequencer state type and the
// command validation function used when a Command write or autoexec fires.
package dm_abstract_cmd_ctrl_pkg;

  localparam logic [7:0]  CmdAccessRegister = 8'h00;
  localparam logic [15:0] RegnoCsrLast      = 16'h0FFF;
  localparam logic [15:0] RegnoGprFirst     = 16'h1000;
  localparam logic [15:0] RegnoGprLast      = 16'h100F;

  typedef enum logic [2:0] {
    CmdErrNone         = 3'd0,
    CmdErrBusy         = 3'd1,
    CmdErrNotSupported = 3'd2,
    CmdErrorException  = 3'd3,
    CmdErrorHaltResume = 3'd4,
    CmdErrorBus        = 3'd5,
    CmdErrorOther      = 3'd7
  } cmderr_e;

  typedef enum logic [1:0] {
    AcIdle,
    AcGo,
    AcExec
  } ac_state_e;

  typedef struct packed {
    logic        zero1;
    logic [2:0]  aarsize;
    logic        aarpostincrement;
    logic        postexec;
    logic        transfer;
    logic        write;
    logic [15:0] regno;
  } ac_ar_cmd_t;

  typedef struct packed {
    logic [7:0] cmdtype;
    ac_ar_cmd_t control;
  } command_t;

  // Returns CmdErrNone when the command may proceed (including a no-op).
  function automatic cmderr_e ac_cmd_check(command_t cmd, bit cheri_en, logic halted);
    if (cmd.cmdtype != CmdAccessRegister) return CmdErrNotSupported;
    if (cmd.control.transfer &&
        !(cmd.control.aarsize == 3'd2 || (cheri_en && cmd.control.aarsize == 3'd3)))
      return CmdErrNotSupported;
    if (cmd.control.transfer &&
        !(cmd.control.regno <= RegnoCsrLast ||
          (cmd.control.regno >= RegnoGprFirst && cmd.control.regno <= RegnoGprLast)))
      return CmdErrNotSupported;
    if (!halted) return CmdErrorHaltResume;
    return CmdErrNone;
  endfunction

endpackage

// File: rtl/dm_abstract_cmd_ctrl_if.sv
// Bundle of DMI-side command signals and hart-side go/resume handshake.
// master: register file + hart side (drives requests, observes status).
// slave : the abstract command sequencer.
interface dm_abstract_cmd_ctrl_if;
  logic        cmd_valid;    // single-cycle Command write
  logic [31:0] cmd;          // written Command value
  logic        autoexec;     // autoexec hit, re-runs last_cmd
  logic        busy_access;  // DMI access that is illegal while busy
  logic [2:0]  cmderr_clr;   // W1C mask for cmderr
  logic        hart_halted;
  logic        going;
  logic        done;
  logic        exception;
  logic        go;
  logic        busy;
  logic [2:0]  cmderr;
  logic [31:0] last_cmd;

  modport master (
    output cmd_valid, cmd, autoexec, busy_access, cmderr_clr,
           hart_halted, going, done, exception,
    input  go, busy, cmderr, last_cmd
  );

  modport slave (
    input  cmd_valid, cmd, autoexec, busy_access, cmderr_clr,
           hart_halted, going, done, exception,
    output go, busy, cmderr, last_cmd
  );
endinterface

// File: rtl/dm_ac_timer.sv
// Cycle counter for bounding an in-flight abstract/system-bus operation.
// Ports: clk_i/rst_ni clock and async active-low reset, clear_i zeroes the
// count, enable_i counts one per cycle, expired_o flags the last allowed
// cycle (Cycles cycles have elapsed including the current one).
module dm_ac_timer #(
  parameter int unsigned Cycles = 1024,
  parameter int unsigned W      = $clog2(Cycles + 1)
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)       cnt_d = '0;
    else if (enable_i) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expired_o = enable_i && (cnt_q == W'(Cycles - 1));
endmodule

// File: rtl/dm_abstract_cmd_ctrl.sv
// Abstract command sequencer of the debug module. Validates Command writes
// and autoexec triggers, runs the go/going/done handshake with the halted
// hart, keeps busy and the sticky cmderr, latches the last command and
// applies regno postincrement and a Go+Exec timeout.
// Ports: clk_i, rst_ni (async active-low), dmactive_i (0 = sync clear),
// bus (slave modport: DMI command inputs, hart handshake, status outputs).
module dm_abstract_cmd_ctrl
  import dm_abstract_cmd_ctrl_pkg::*;
#(
  parameter bit          CheriEn       = 1'b1,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  dmactive_i,
  dm_abstract_cmd_ctrl_if.slave bus
);
  localparam int unsigned TimeoutW = $clog2(TimeoutCycles + 1);

  ac_state_e state_q, state_d;
  logic      go_q, go_d, busy_q, busy_d;
  cmderr_e   cmderr_q, cmderr_d, new_err;
  command_t  last_cmd_q, last_cmd_d, eff_cmd;
  cmderr_e   chk_err;
  logic      trigger, err_set, timer_clr, timer_exp;

  dm_ac_timer #(
    .Cycles (TimeoutCycles),
    .W      (TimeoutW)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (timer_clr || !dmactive_i),
    .enable_i  (busy_q),
    .expired_o (timer_exp)
  );

  always_comb begin
    trigger    = bus.cmd_valid || bus.autoexec;
    eff_cmd    = bus.cmd_valid ? command_t'(bus.cmd) : last_cmd_q;
    chk_err    = ac_cmd_check(eff_cmd, CheriEn, bus.hart_halted);
    state_d    = state_q;
    last_cmd_d = last_cmd_q;
    err_set    = 1'b0;
    new_err    = CmdErrNone;
    timer_clr  = 1'b0;

    unique case (state_q)
      AcIdle: begin
        if (bus.cmd_valid) last_cmd_d = command_t'(bus.cmd);
        if (trigger && cmderr_q == CmdErrNone) begin
          if (chk_err != CmdErrNone) begin
            err_set = 1'b1;
            new_err = chk_err;
          end else if (eff_cmd.control.transfer || eff_cmd.control.postexec) begin
            state_d   = AcGo;
            timer_clr = 1'b1;
          end
        end
      end
      AcGo: begin
        if (bus.going) begin
          state_d = AcExec;
        end else if (timer_exp) begin
          state_d = AcIdle;
          err_set = 1'b1;
          new_err = CmdErrorOther;
        end
      end
      AcExec: begin
        if (bus.exception) begin
          state_d = AcIdle;
          err_set = 1'b1;
          new_err = CmdErrorException;
        end else if (bus.done) begin
          state_d = AcIdle;
          if (last_cmd_q.control.aarpostincrement && last_cmd_q.control.transfer)
            last_cmd_d.control.regno = last_cmd_q.control.regno + 16'd1;
        end else if (timer_exp) begin
          state_d = AcIdle;
          err_set = 1'b1;
          new_err = CmdErrorOther;
        end
      end
      default: state_d = AcIdle;
    endcase

    if (busy_q && bus.busy_access) begin
      err_set = 1'b1;
      new_err = CmdErrBusy;
    end

    // Only the first error sticks; a fresh error overrides a same-cycle clear.
    if (err_set && cmderr_q == CmdErrNone) cmderr_d = new_err;
    else                                   cmderr_d = cmderr_e'(cmderr_q & ~bus.cmderr_clr);

    busy_d = (state_d != AcIdle);
    go_d   = (state_d == AcGo);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= AcIdle;
      go_q       <= 1'b0;
      busy_q     <= 1'b0;
      cmderr_q   <= CmdErrNone;
      last_cmd_q <= '0;
    end else if (!dmactive_i) begin
      state_q    <= AcIdle;
      go_q       <= 1'b0;
      busy_q     <= 1'b0;
      cmderr_q   <= CmdErrNone;
      last_cmd_q <= '0;
    end else begin
      state_q    <= state_d;
      go_q       <= go_d;
      busy_q     <= busy_d;
      cmderr_q   <= cmderr_d;
      last_cmd_q <= last_cmd_d;
    end
  end

  assign bus.go       = go_q;
  assign bus.busy     = busy_q;
  assign bus.cmderr   = cmderr_q;
  assign bus.last_cmd = last_cmd_q;
endmodule

// File: tb/tb_dm_abstract_cmd_ctrl.sv
module tb_dm_abstract_cmd_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dmactive = 1'b0;
  always #5 clk = ~clk;

  dm_abstract_cmd_ctrl_if bus ();

  dm_abstract_cmd_ctrl #(
    .CheriEn       (1'b0),
    .TimeoutCycles (8)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .dmactive_i (dmactive),
    .bus        (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] m_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] c);
    bus.cmd_valid = 1'b1;
    bus.cmd = c;
    cyc();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic clear_err();
    bus.cmderr_clr = 3'b111;
    cyc();
    bus.cmderr_clr = 3'b000;
    chk("cmderr_cleared", 32'(bus.cmderr), 32'd0);
  endtask

  // Entered one cycle after an accepted trigger; hart answers after go_wait cycles.
  task automatic run_accepted(input int go_wait, input int exec_wait, input bit exc);
    for (int i = 0; i < go_wait; i++) begin
      chk("go_held", 32'(bus.go), 32'd1);
      cyc();
    end
    bus.going = 1'b1;
    cyc();
    bus.going = 1'b0;
    chk("go_drop", 32'(bus.go), 32'd0);
    chk("busy_exec", 32'(bus.busy), 32'd1);
    for (int i = 0; i < exec_wait; i++) cyc();
    bus.done = 1'b1;
    bus.exception = exc;
    cyc();
    bus.done = 1'b0;
    bus.exception = 1'b0;
    chk("busy_end", 32'(bus.busy), 32'd0);
  endtask

  // Expected validation result written from the field rules, CheriEn=0.
  function automatic logic [2:0] exp_err(input logic [31:0] c, input bit halted);
    logic [31:0] ctype, size, xfer, regno;
    ctype = c >> 24;
    size  = (c >> 20) & 32'd7;
    xfer  = (c >> 17) & 32'd1;
    regno = c & 32'hFFFF;
    if (ctype != 0) return 3'd2;
    if (xfer == 1 && size != 2) return 3'd2;
    if (xfer == 1 && regno > 32'h100F) return 3'd2;
    if (!halted) return 3'd4;
    return 3'd0;
  endfunction

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd = '0; bus.autoexec = 1'b0; bus.busy_access = 1'b0;
    bus.cmderr_clr = '0; bus.hart_halted = 1'b0; bus.going = 1'b0; bus.done = 1'b0;
    bus.exception = 1'b0;
    dmactive = 1'b1;
    #2;
    chk("rst_go", 32'(bus.go), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_cmderr", 32'(bus.cmderr), 32'd0);
    chk("rst_last", bus.last_cmd, 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // Basic accepted register access
    bus.hart_halted = 1'b1;
    issue(32'h0022_1008);
    chk("t1_go", 32'(bus.go), 32'd1);
    chk("t1_busy", 32'(bus.busy), 32'd1);
    chk("t1_last", bus.last_cmd, 32'h0022_1008);
    run_accepted(2, 0, 1'b0);
    chk("t1_cmderr", 32'(bus.cmderr), 32'd0);
    chk("t1_last_end", bus.last_cmd, 32'h0022_1008);

    // aarsize 3 illegal without CHERI; sticky error blocks later commands
    issue(32'h0032_1008);
    chk("t2_cmderr", 32'(bus.cmderr), 32'd2);
    chk("t2_busy", 32'(bus.busy), 32'd0);
    chk("t2_go", 32'(bus.go), 32'd0);
    issue(32'h0022_1008);
    chk("t2_ignored_busy", 32'(bus.busy), 32'd0);
    chk("t2_ignored_err", 32'(bus.cmderr), 32'd2);
    chk("t2_last_upd", bus.last_cmd, 32'h0022_1008);
    clear_err();
    issue(32'h0022_1008);
    chk("t2_retry_busy", 32'(bus.busy), 32'd1);
    run_accepted(1, 1, 1'b0);

    // Hart not halted; unsupported cmdtype
    bus.hart_halted = 1'b0;
    issue(32'h0022_1001);
    chk("t3_haltresume", 32'(bus.cmderr), 32'd4);
    chk("t3_busy", 32'(bus.busy), 32'd0);
    clear_err();
    bus.hart_halted = 1'b1;
    issue(32'h0200_0000);
    chk("t3_cmdtype", 32'(bus.cmderr), 32'd2);
    clear_err();

    // Postincrement past the GPR range, then autoexec re-run fails
    issue(32'h002A_100F);
    chk("t4_busy", 32'(bus.busy), 32'd1);
    run_accepted(1, 0, 1'b0);
    chk("t4_postinc", bus.last_cmd, 32'h002A_1010);
    chk("t4_cmderr", 32'(bus.cmderr), 32'd0);
    bus.autoexec = 1'b1;
    cyc();
    bus.autoexec = 1'b0;
    chk("t4_autoexec_err", 32'(bus.cmderr), 32'd2);
    chk("t4_autoexec_busy", 32'(bus.busy), 32'd0);
    clear_err();

    // Busy access during Exec, then done+exception together
    issue(32'h0022_1008);
    bus.going = 1'b1;
    cyc();
    bus.going = 1'b0;
    bus.busy_access = 1'b1;
    cyc();
    bus.busy_access = 1'b0;
    chk("t5_busyerr", 32'(bus.cmderr), 32'd1);
    chk("t5_still_busy", 32'(bus.busy), 32'd1);
    bus.done = 1'b1; bus.exception = 1'b1;
    cyc();
    bus.done = 1'b0; bus.exception = 1'b0;
    chk("t5_busy_end", 32'(bus.busy), 32'd0);
    chk("t5_err_kept", 32'(bus.cmderr), 32'd1);
    clear_err();

    // Timeout: going never arrives
    issue(32'h0022_1008);
    for (int i = 0; i < 8; i++) begin
      chk("t6_busy_window", 32'(bus.busy), 32'd1);
      cyc();
    end
    chk("t6_busy_to", 32'(bus.busy), 32'd0);
    chk("t6_go_to", 32'(bus.go), 32'd0);
    chk("t6_err_to", 32'(bus.cmderr), 32'd7);
    clear_err();

    // dmactive drop mid-Exec
    issue(32'h002A_1003);
    bus.going = 1'b1;
    cyc();
    bus.going = 1'b0;
    dmactive = 1'b0;
    cyc();
    dmactive = 1'b1;
    chk("t7_go", 32'(bus.go), 32'd0);
    chk("t7_busy", 32'(bus.busy), 32'd0);
    chk("t7_cmderr", 32'(bus.cmderr), 32'd0);
    chk("t7_last", bus.last_cmd, 32'd0);

    // No-op: no transfer, no postexec
    issue(32'h0070_1234);
    chk("t8_noop_busy", 32'(bus.busy), 32'd0);
    chk("t8_noop_err", 32'(bus.cmderr), 32'd0);
    chk("t8_noop_last", bus.last_cmd, 32'h0070_1234);
    m_last = 32'h0070_1234;

    // Randomized transactions against the field-rule model
    for (int it = 0; it < 60; it++) begin
      logic [31:0] c, eff, rsel;
      logic [2:0]  e;
      bit use_cmd, halted, exc, postinc, xfer, pexec;
      rsel = 32'($urandom_range(0, 3));
      c[31:24] = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 3)) : 8'h00;
      c[23] = 1'b0;
      c[22:20] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
      c[19:16] = 4'($urandom_range(0, 15));
      c[15:0] = (rsel == 0) ? 16'($urandom) :
                (rsel == 1) ? 16'($urandom_range(0, 16'h0FFF)) :
                (rsel == 2) ? 16'($urandom_range(16'h1000, 16'h101F)) : 16'hFFFF;
      use_cmd = ($urandom_range(0, 3) != 0);
      halted  = ($urandom_range(0, 5) != 0);
      exc     = ($urandom_range(0, 5) == 0);
      bus.hart_halted = halted;
      bus.cmd_valid   = use_cmd;
      bus.cmd         = c;
      bus.autoexec    = ($urandom_range(0, 1) == 1) || !use_cmd;
      cyc();
      bus.cmd_valid = 1'b0;
      bus.autoexec  = 1'b0;
      if (use_cmd) m_last = c;
      eff = m_last;
      e = exp_err(eff, halted);
      postinc = eff[19]; pexec = eff[18]; xfer = eff[17];
      if (e != 3'd0) begin
        chk("rnd_err", 32'(bus.cmderr), 32'(e));
        chk("rnd_err_busy", 32'(bus.busy), 32'd0);
        clear_err();
      end else if (!xfer && !pexec) begin
        chk("rnd_noop_busy", 32'(bus.busy), 32'd0);
        chk("rnd_noop_err", 32'(bus.cmderr), 32'd0);
      end else begin
        chk("rnd_go", 32'(bus.go), 32'd1);
        run_accepted($urandom_range(0, 3), $urandom_range(0, 2), exc);
        if (!exc && postinc && xfer) m_last[15:0] = m_last[15:0] + 16'd1;
        chk("rnd_cmderr", 32'(bus.cmderr), exc ? 32'd3 : 32'd0);
        if (exc) clear_err();
      end
      chk("rnd_last", bus.last_cmd, m_last);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
